// File: rtl/router_source_arbiter.sv
// Round-robin arbiter sharing the 6-bit secure-router input among four packet sources.
// Each winning packet is held on d_out for a full frame plus a guard gap before the next arbitration.
module router_source_arbiter #(
  parameter int FRAME_LEN = 8,
  parameter int GAP_LEN   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [0:5] pkt0,
  input  logic [0:5] pkt1,
  input  logic [0:5] pkt2,
  input  logic [0:5] pkt3,
  output logic [3:0] grant,
  output logic [0:5] d_out,
  output logic       launch,
  output logic       busy,
  output logic [1:0] cur_src,
  output logic [7:0] frames_sent,
  output logic [1:0] dbg_state
);

  localparam int FW = (FRAME_LEN > 0) ? $clog2(FRAME_LEN + 1) : 1;
  localparam int GW = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [1:0]  r_ptr;
  logic [3:0]  r_grant;
  logic [0:5]  r_d_out;
  logic        r_launch;
  logic [1:0]  r_cur_src;
  logic [7:0]  r_frames;
  logic [FW-1:0] r_frame_cnt;
  logic [FW-1:0] w_next_frame_cnt;
  logic [GW-1:0] r_gap_cnt;
  logic [GW-1:0] w_next_gap_cnt;

  logic        w_found;
  logic [1:0]  w_winner;
  logic [0:5]  w_pkt;
  logic        w_arb;

  // Search starts just after the last winner, so the last-served source has lowest priority.
  always_comb begin
    logic [1:0] idx;
    w_found  = 1'b0;
    w_winner = r_ptr;
    idx      = r_ptr;
    for (int k = 1; k <= 4; k++) begin
      idx = r_ptr + 2'(k);
      if (!w_found && req[idx]) begin
        w_found  = 1'b1;
        w_winner = idx;
      end
    end
  end

  always_comb begin
    case (w_winner)
      2'd0:    w_pkt = pkt0;
      2'd1:    w_pkt = pkt1;
      2'd2:    w_pkt = pkt2;
      default: w_pkt = pkt3;
    endcase
  end

  // The launch cycle is the first HOLD cycle, so HOLD spans the whole FRAME_LEN-cycle frame.
  always_comb begin
    w_next_state     = r_state;
    w_next_frame_cnt = r_frame_cnt;
    w_next_gap_cnt   = r_gap_cnt;
    w_arb            = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_arb            = 1'b1;
          w_next_state     = S_HOLD;
          w_next_frame_cnt = FW'(FRAME_LEN);
        end
      end
      S_HOLD: begin
        if (r_frame_cnt <= FW'(1)) begin
          if (GAP_LEN > 0) begin
            w_next_state   = S_GAP;
            w_next_gap_cnt = GW'(GAP_LEN);
          end else begin
            w_next_state = S_IDLE;
          end
        end else begin
          w_next_frame_cnt = r_frame_cnt - FW'(1);
        end
      end
      S_GAP: begin
        if (r_gap_cnt <= GW'(1)) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_gap_cnt = r_gap_cnt - GW'(1);
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= 2'd3;
      r_grant     <= 4'b0000;
      r_d_out     <= 6'b000000;
      r_launch    <= 1'b0;
      r_cur_src   <= 2'd0;
      r_frames    <= 8'd0;
      r_frame_cnt <= '0;
      r_gap_cnt   <= '0;
    end else begin
      r_state     <= w_next_state;
      r_frame_cnt <= w_next_frame_cnt;
      r_gap_cnt   <= w_next_gap_cnt;
      r_launch    <= w_arb;
      r_grant     <= w_arb ? (4'b0001 << w_winner) : 4'b0000;
      if (w_arb) begin
        r_d_out   <= w_pkt;
        r_cur_src <= w_winner;
        r_ptr     <= w_winner;
        r_frames  <= r_frames + 8'd1;
      end
    end
  end

  assign grant       = r_grant;
  assign d_out       = r_d_out;
  assign launch      = r_launch;
  assign busy        = (r_state != S_IDLE);
  assign cur_src     = r_cur_src;
  assign frames_sent = r_frames;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_router_source_arbiter.sv
// Bench for router_source_arbiter: a directed vector table, then multi-cycle sequences
// for contention, fairness, mid-frame changes, reset in HOLD, counter wrap and GAP_LEN=0.
module tb_router_source_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [0:5] pkt0, pkt1, pkt2, pkt3;
  logic [3:0] grant;
  logic [0:5] d_out;
  logic       launch, busy;
  logic [1:0] cur_src;
  logic [7:0] frames_sent;
  logic [1:0] dbg_state;

  logic [3:0] req_g;
  logic [3:0] grant_g;
  logic [0:5] d_out_g;
  logic       launch_g, busy_g;
  logic [1:0] cur_src_g;
  logic [7:0] frames_sent_g;
  logic [1:0] dbg_state_g;

  int checks;
  int failures;

  router_source_arbiter #(.FRAME_LEN(8), .GAP_LEN(2)) dut (
    .clk(clk), .rst(rst), .req(req),
    .pkt0(pkt0), .pkt1(pkt1), .pkt2(pkt2), .pkt3(pkt3),
    .grant(grant), .d_out(d_out), .launch(launch), .busy(busy),
    .cur_src(cur_src), .frames_sent(frames_sent), .dbg_state(dbg_state)
  );

  router_source_arbiter #(.FRAME_LEN(8), .GAP_LEN(0)) dut_g0 (
    .clk(clk), .rst(rst), .req(req_g),
    .pkt0(pkt0), .pkt1(pkt1), .pkt2(pkt2), .pkt3(pkt3),
    .grant(grant_g), .d_out(d_out_g), .launch(launch_g), .busy(busy_g),
    .cur_src(cur_src_g), .frames_sent(frames_sent_g), .dbg_state(dbg_state_g)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [5:0] pkt0;
    logic [3:0] grant;
    logic [5:0] d_out;
    logic       launch;
    logic       busy;
    logic [1:0] cur_src;
    logic [7:0] fs;
  } vec_t;

  vec_t vecs[13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst   = 1'b0;
    req   = 4'b0000;
    req_g = 4'b0000;
    step();
    rst = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_grant"},  grant, 0);
    chk({tag, "_d_out"},  d_out, 0);
    chk({tag, "_launch"}, launch, 0);
    chk({tag, "_busy"},   busy, 0);
    chk({tag, "_cur_src"}, cur_src, 0);
    chk({tag, "_frames"}, frames_sent, 0);
  endtask

  initial begin
    logic [5:0] exp_pkt[4];
    logic [5:0] pa;
    int n, ng, last, lastg, cyc;

    checks   = 0;
    failures = 0;
    rst  = 1'b1;
    req  = 4'b0000;
    req_g = 4'b0000;
    pkt0 = 6'b000000; pkt1 = 6'b011100; pkt2 = 6'b000000; pkt3 = 6'b000000;

    // Single request, busy window, no regrant, then a round-robin follow-up.
    vecs[0] = '{4'b0001, 6'b101011, 4'b0001, 6'b101011, 1'b1, 1'b1, 2'd0, 8'd1};
    for (int i = 1; i <= 9; i++)
      vecs[i] = '{4'b0000, 6'b000000, 4'b0000, 6'b101011, 1'b0, 1'b1, 2'd0, 8'd1};
    vecs[10] = '{4'b0000, 6'b000000, 4'b0000, 6'b101011, 1'b0, 1'b0, 2'd0, 8'd1};
    vecs[11] = '{4'b0000, 6'b000000, 4'b0000, 6'b101011, 1'b0, 1'b0, 2'd0, 8'd1};
    vecs[12] = '{4'b0010, 6'b000000, 4'b0010, 6'b011100, 1'b1, 1'b1, 2'd1, 8'd2};

    do_reset();
    chk_zero("reset");

    for (int i = 0; i < 13; i++) begin
      req  = vecs[i].req;
      pkt0 = vecs[i].pkt0;
      step();
      chk($sformatf("vec%0d_grant", i),   grant,       vecs[i].grant);
      chk($sformatf("vec%0d_d_out", i),   d_out,       vecs[i].d_out);
      chk($sformatf("vec%0d_launch", i),  launch,      vecs[i].launch);
      chk($sformatf("vec%0d_busy", i),    busy,        vecs[i].busy);
      chk($sformatf("vec%0d_cur_src", i), cur_src,     vecs[i].cur_src);
      chk($sformatf("vec%0d_frames", i),  frames_sent, vecs[i].fs);
    end

    // All-four contention with req held: 0,1,2,3,0 every 11 cycles.
    do_reset();
    exp_pkt[0] = 6'b010001; exp_pkt[1] = 6'b100010;
    exp_pkt[2] = 6'b110100; exp_pkt[3] = 6'b001000;
    pkt0 = exp_pkt[0]; pkt1 = exp_pkt[1]; pkt2 = exp_pkt[2]; pkt3 = exp_pkt[3];
    req = 4'b1111;
    for (int c = 0; c <= 44; c++) begin
      step();
      chk($sformatf("rr_c%0d_launch", c), launch, (c % 11) == 0);
      chk($sformatf("rr_c%0d_grant", c), grant,
          ((c % 11) == 0) ? (32'd1 << ((c / 11) % 4)) : 32'd0);
      chk($sformatf("rr_c%0d_busy", c), busy, (c % 11) != 10);
      if ((c % 11) == 0) begin
        chk($sformatf("rr_c%0d_d_out", c), d_out, exp_pkt[(c / 11) % 4]);
        chk($sformatf("rr_c%0d_cur_src", c), cur_src, (c / 11) % 4);
      end
    end
    req = 4'b0000;

    // Fairness: after source 2, req=1010 serves 3 then 1.
    do_reset();
    pkt2 = 6'b111000; pkt3 = 6'b000111; pkt1 = 6'b101010;
    req = 4'b0100;
    step();
    chk("fair_grant2", grant, 4'b0100);
    req = 4'b0000;
    for (int s = 1; s <= 10; s++) begin
      step();
      chk($sformatf("fair_busy%0d", s), busy, s <= 9);
    end
    req = 4'b1010;
    step();
    chk("fair_grant3", grant, 4'b1000);
    chk("fair_d3", d_out, 6'b000111);
    chk("fair_src3", cur_src, 3);
    for (int s = 1; s <= 11; s++) begin
      step();
      chk($sformatf("fair_s%0d_grant", s), grant, (s == 11) ? 4'b0010 : 4'b0000);
    end
    chk("fair_d1", d_out, 6'b101010);
    chk("fair_src1", cur_src, 1);
    req = 4'b0000;

    // Mid-frame pkt change and transient req[1] are ignored.
    do_reset();
    pa = 6'b110110;
    pkt0 = pa;
    req = 4'b0001;
    step();
    chk("mid_launch", launch, 1);
    chk("mid_d0", d_out, pa);
    req = 4'b0000;
    for (int s = 1; s <= 12; s++) begin
      if (s == 3) begin
        pkt0 = 6'b001001;
        req  = 4'b0010;
      end else if (s == 4) begin
        req = 4'b0000;
      end
      step();
      chk($sformatf("mid_s%0d_grant", s), grant, 0);
      chk($sformatf("mid_s%0d_d_out", s), d_out, pa);
      chk($sformatf("mid_s%0d_busy", s), busy, s <= 9);
    end

    // Reset at the 4th frame cycle abandons the frame and restores the pointer.
    do_reset();
    pkt0 = 6'b011011;
    req = 4'b0001;
    step();
    req = 4'b0000;
    step(); step(); step();
    chk("rsth_busy_before", busy, 1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk_zero("rsth");
    req = 4'b1111;
    step();
    chk("rsth_grant0", grant, 4'b0001);
    chk("rsth_src0", cur_src, 0);
    req = 4'b0000;

    // Counter wrap on the default build; 9-cycle spacing on the GAP_LEN=0 build.
    do_reset();
    pkt0 = 6'b100001;
    req   = 4'b0001;
    req_g = 4'b0001;
    n = 0; ng = 0; last = -1; lastg = -1; cyc = 0;
    while (n < 256 && cyc < 4000) begin
      step();
      cyc++;
      if (launch) begin
        n++;
        if (n >= 250 || n <= 3)
          chk($sformatf("wrap_n%0d_frames", n), frames_sent, n % 256);
        if (last >= 0 && n <= 12)
          chk($sformatf("wrap_n%0d_spacing", n), cyc - last, 11);
        last = cyc;
      end
      if (launch_g) begin
        ng++;
        if (lastg >= 0 && ng <= 12)
          chk($sformatf("gap0_n%0d_spacing", ng), cyc - lastg, 9);
        lastg = cyc;
      end
    end
    chk("wrap_count", n, 256);
    chk("wrap_final_frames", frames_sent, 0);
    req = 4'b0000;
    req_g = 4'b0000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/router_source_arbiter.md
Name: router_source_arbiter

Overview:
- Shares the single 6-bit secure-router input among four packet sources.
- Arbitrates round-robin and presents the winner's packet to the router.
- Holds the packet stable for one full serial frame plus a guard gap, so the router's data lines and strobes never see a mid-frame change.
- Sits directly upstream of the router input d_in; the injection and correction lanes downstream are unaffected.

Parameters:
- FRAME_LEN, 8, cycles d_out is held per packet including the launch cycle (7 codeword bits + 1); legal range >=1.
- GAP_LEN, 2, idle guard cycles after each frame before re-arbitration; legal range >=0.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-low reset.
- req  input  [3:0]  per-source request; bit i = source i has a packet on pkt_i.
- pkt0  input  [0:5]  source 0 packet; [0:1] = destination line, [2:5] = data nibble.
- pkt1  input  [0:5]  source 1 packet, same format as pkt0.
- pkt2  input  [0:5]  source 2 packet, same format as pkt0.
- pkt3  input  [0:5]  source 3 packet, same format as pkt0.
- grant  output  [3:0]  one-hot, single-cycle acknowledge to the source whose packet was captured.
- d_out  output  [0:5]  packet to the router d_in.
- launch  output  1  single-cycle pulse in the first cycle d_out carries a new packet.
- busy  output  1  high from the launch cycle through the last GAP cycle.
- cur_src  output  [1:0]  index of the source currently or last served.
- frames_sent  output  [7:0]  count of launched packets; wraps 255 -> 0.

Behaviour:
- Reset: applies when rst=0 at a clock edge; asynchronous assertion has no effect until that edge. Effect on the next cycle:
  - grant=0, d_out=0, launch=0, busy=0, cur_src=0, frames_sent=0.
  - State IDLE; round-robin pointer=3, so source 0 has highest priority first.
- State IDLE:
  - Evaluate req each cycle.
  - If req!=0, select the first set bit searching ptr+1, ptr+2, ... modulo 4.
  - At that edge register, all visible in the next cycle:
    - grant = one-hot of the winner.
    - d_out = winner's pkt.
    - cur_src = winner index.
    - launch=1, busy=1.
    - ptr = winner index.
    - frames_sent = frames_sent+1, wrapping modulo 256.
  - Then go to HOLD, or to GAP/IDLE per the rules below when FRAME_LEN=1.
- Timing and latency:
  - Launch cycle = first cycle of the frame.
  - grant and launch are high together for exactly one cycle.
  - Request-to-grant latency = 1 cycle from IDLE.
- State HOLD:
  - Lasts FRAME_LEN-1 further cycles; d_out stable, launch=0, busy=1.
  - Next state GAP if GAP_LEN>0, else IDLE.
- State GAP:
  - Lasts GAP_LEN cycles; busy=1, d_out unchanged.
  - Then IDLE.
- IDLE outputs: busy=0. d_out and cur_src retain their last values; they are not cleared.
- Spacing: minimum launch-to-launch spacing is FRAME_LEN+GAP_LEN+1 cycles (11 at defaults), because IDLE lasts at least one cycle.
- Request handling:
  - req is sampled only in IDLE; requests raised or dropped while busy are not latched.
  - A source that drops req before its grant is never granted.
  - A source whose req stays high after grant is treated as a new request and competes again with lowest priority.
  - pkt_i is sampled only at the arbitration edge; later changes do not affect d_out.
- Simultaneous requests: resolved purely by the round-robin order from ptr+1; no fixed priority beyond reset.
- Counters:
  - Frame counter width = clog2(FRAME_LEN+1); gap counter width = clog2(GAP_LEN+1).
  - Both load at state entry and count down to 1.
- Reset mid-operation (HOLD or GAP): the frame is abandoned, all outputs go to reset values the next cycle, and the pointer returns to 3.
- Bit order: no reordering of the six bits; d_out[k] = pkt_winner[k].

Test Plan:
- Single request: after reset, req=4'b0001, pkt0=6'b10_1011 for one cycle -> next cycle grant=0001, launch=1, d_out=101011, cur_src=0, frames_sent=1. busy is high 10 cycles, then low. No further grant.
- All-four contention: req=4'b1111 held constant -> launches in source order 0,1,2,3,0 at cycles t, t+11, t+22, t+33, t+44. Each grant is one-hot single-cycle and d_out matches the granted pkt.
- Round-robin fairness: after source 2 is served, raise req=4'b1010 in IDLE -> source 3 granted first, source 1 granted 11 cycles later.
- Mid-frame changes: during HOLD change pkt0 and raise req[1] then drop it -> d_out unchanged through HOLD/GAP, and source 1 is never granted.
- Reset in HOLD: rst=0 for one edge at the 4th frame cycle -> next cycle all outputs 0 and busy=0. Then req=4'b1111 -> source 0 is granted first.
- Counter wrap: 256 single-source launches -> frames_sent reads 255, then 0 on the 256th launch; the GAP_LEN=0 build gives 9-cycle launch spacing.
